// File: rtl/argon_pkg.sv
// Shared branch-unit package: branch-type codes, the compare flag bundle and its field width.
package argon_pkg;

    localparam int BT_WIDTH = 6;

    localparam logic [BT_WIDTH-1:0] BEQ  = 6'd0;
    localparam logic [BT_WIDTH-1:0] BNE  = 6'd1;
    localparam logic [BT_WIDTH-1:0] BGE  = 6'd2;
    localparam logic [BT_WIDTH-1:0] BGEU = 6'd3;
    localparam logic [BT_WIDTH-1:0] BLT  = 6'd4;
    localparam logic [BT_WIDTH-1:0] BLTU = 6'd5;

    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
        logic carry;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_flag_core.sv
// Combinational A-B and zero/sign/overflow/carry derivation; carry means "no borrow" (A >= B unsigned).
module cmp_flag_core
    import argon_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output cmp_flags_t       flags
);

    logic [WIDTH:0] diff;

    // Two's-complement subtract with the carry-out kept as the no-borrow bit
    assign diff = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

    assign flags.zero     = (diff[WIDTH-1:0] == '0);
    assign flags.sign     = diff[WIDTH-1];
    assign flags.overflow = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    assign flags.carry    = diff[WIDTH];

endmodule

// File: rtl/cmp_flag_gen.sv
// Pipelined compare unit: operand stage S1, flag stage S2, valid/ready on both sides.
// Define CMP_FLAG_BYPASS_EN to drop S1 and register flags straight from the inputs (latency 1).
module cmp_flag_gen
    import argon_pkg::cmp_flags_t;
#(
    parameter int WIDTH    = 16,
    parameter int BT_WIDTH = argon_pkg::BT_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTH-1:0]    i_op_a,
    input  logic [WIDTH-1:0]    i_op_b,
    input  logic [BT_WIDTH-1:0] i_branch_type,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_flag_zero,
    output logic                o_flag_sign,
    output logic                o_flag_overflow,
    output logic                o_flag_carry,
    output logic [BT_WIDTH-1:0] o_branch_type
);

    // Handshake: a beat transfers on any rising edge where valid && ready on that side.
    // Producers hold valid and data until accepted; o_ready depends combinationally on i_ready.

    logic                s2_v;
    cmp_flags_t          s2_flags;
    logic [BT_WIDTH-1:0] s2_type;
    logic                s2_adv;

    logic                stage_v;
    cmp_flags_t          stage_flags;
    logic [BT_WIDTH-1:0] stage_type;

    assign s2_adv = !s2_v || i_ready;

`ifdef CMP_FLAG_BYPASS_EN

    cmp_flag_core #(.WIDTH(WIDTH)) u_core (
        .op_a  (i_op_a),
        .op_b  (i_op_b),
        .flags (stage_flags)
    );

    assign stage_v    = i_valid;
    assign stage_type = i_branch_type;
    assign o_ready    = s2_adv;

`else

    logic                s1_v;
    logic [WIDTH-1:0]    s1_a;
    logic [WIDTH-1:0]    s1_b;
    logic [BT_WIDTH-1:0] s1_type;
    logic                s1_adv;

    assign s1_adv  = !s1_v || s2_adv;
    assign o_ready = s1_adv;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_type <= '0;
        end else if (s1_adv) begin
            s1_v <= i_valid;
            if (i_valid) begin
                s1_a    <= i_op_a;
                s1_b    <= i_op_b;
                s1_type <= i_branch_type;
            end
        end
    end

    cmp_flag_core #(.WIDTH(WIDTH)) u_core (
        .op_a  (s1_a),
        .op_b  (s1_b),
        .flags (stage_flags)
    );

    assign stage_v    = s1_v;
    assign stage_type = s1_type;

`endif

    // S2 only reloads on a valid beat, so a drained slot keeps its last payload
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_v     <= 1'b0;
            s2_flags <= '0;
            s2_type  <= '0;
        end else if (s2_adv) begin
            s2_v <= stage_v;
            if (stage_v) begin
                s2_flags <= stage_flags;
                s2_type  <= stage_type;
            end
        end
    end

    assign o_valid         = s2_v;
    assign o_flag_zero     = s2_flags.zero;
    assign o_flag_sign     = s2_flags.sign;
    assign o_flag_overflow = s2_flags.overflow;
    assign o_flag_carry    = s2_flags.carry;
    assign o_branch_type   = s2_type;

endmodule

// File: tb/tb_cmp_flag_gen.sv
// Bench for cmp_flag_gen: directed vectors, streaming, backpressure and reset, plus random traffic,
// scored against an arithmetic model of the flags and an occupancy/latency model of the pipe.
module tb_cmp_flag_gen;

    localparam int WIDTH = 16;
    localparam int BT_W  = 6;
    localparam int W     = 4 + BT_W;
`ifdef CMP_FLAG_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [WIDTH-1:0]  i_op_a = '0;
    logic [WIDTH-1:0]  i_op_b = '0;
    logic [BT_W-1:0]   i_branch_type = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic              o_flag_zero;
    logic              o_flag_sign;
    logic              o_flag_overflow;
    logic              o_flag_carry;
    logic [BT_W-1:0]   o_branch_type;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    logic [W-1:0] exp_q[$];
    int           vis_q[$];

    cmp_flag_gen #(.WIDTH(WIDTH), .BT_WIDTH(BT_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_op_a          (i_op_a),
        .i_op_b          (i_op_b),
        .i_branch_type   (i_branch_type),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_flag_zero     (o_flag_zero),
        .o_flag_sign     (o_flag_sign),
        .o_flag_overflow (o_flag_overflow),
        .o_flag_carry    (o_flag_carry),
        .o_branch_type   (o_branch_type)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Flags from plain integer arithmetic on the operands
    function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [BT_W-1:0] t);
        longint sa, sb, sd;
        logic [WIDTH-1:0] d;
        logic z, s, v, c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        d  = a - b;
        z  = (a == b);
        c  = (a >= b);
        s  = d[WIDTH-1];
        v  = (sd > 32767) || (sd < -32768);
        return {z, s, v, c, t};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {o_flag_zero, o_flag_sign, o_flag_overflow, o_flag_carry, o_branch_type};
    endfunction

    task automatic run_cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [BT_W-1:0] t, input logic rdy);
        logic exp_ready, exp_valid, acc, pop;
        @(negedge clk);
        i_valid = v; i_op_a = a; i_op_b = b; i_branch_type = t; i_ready = rdy;
        #1;
        exp_ready = (exp_q.size() < LAT) || rdy;
        exp_valid = (exp_q.size() > 0) && (vis_q[0] <= edge_cnt);
        check_eq("o_ready", 64'(o_ready), 64'(exp_ready));
        check_eq("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) check_eq("result", 64'(dut_out()), 64'(exp_q[0]));
        acc = v && exp_ready;
        pop = exp_valid && rdy;
        @(posedge clk);
        edge_cnt++;
        if (pop) begin
            void'(exp_q.pop_front());
            void'(vis_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(model(a, b, t));
            vis_q.push_back(edge_cnt + LAT - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        @(posedge clk);
        edge_cnt++;
        exp_q.delete();
        vis_q.delete();
        #1;
        check_eq("rst_o_valid", 64'(o_valid), 64'd0);
        check_eq("rst_outputs", 64'(dut_out()), 64'd0);
        check_eq("rst_o_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_op(input int mode, input logic [WIDTH-1:0] other);
        case (mode)
            0: return other;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0000;
            4: return 16'hFFFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic rand_cycle(input int pv, input int pr);
        logic [WIDTH-1:0] a, b;
        a = rand_op($urandom_range(1, 9), '0);
        b = rand_op($urandom_range(0, 9), a);
        run_cycle($urandom_range(0, 99) < pv, a, b, BT_W'($urandom_range(0, 63)),
                  $urandom_range(0, 99) < pr);
    endtask

    initial begin
        do_reset();

        run_cycle(1'b1, 16'h0005, 16'h0005, argon_pkg::BEQ,  1'b1);
        run_cycle(1'b1, 16'h0003, 16'h0005, argon_pkg::BLTU, 1'b1);
        run_cycle(1'b1, 16'h8000, 16'h0001, argon_pkg::BLT,  1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, '0, '0, 1'b1);

        // Back-to-back stream, then a held sink while the source keeps offering
        for (int i = 0; i < 8; i++) rand_cycle(100, 100);
        for (int i = 0; i < 5; i++) rand_cycle(100, 0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, '0, '0, 1'b1);

        // Two compares in flight when reset hits
        run_cycle(1'b1, 16'h1234, 16'h0042, argon_pkg::BNE, 1'b0);
        run_cycle(1'b1, 16'h0042, 16'h1234, argon_pkg::BGE, 1'b0);
        do_reset();
        run_cycle(1'b1, 16'hFFFF, 16'h0001, argon_pkg::BGEU, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, '0, '0, 1'b1);

        for (int i = 0; i < 800; i++) rand_cycle(70, 60);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, '0, '0, 1'b1);
        check_eq("drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
